// File: rtl/line_fill_unit.sv
// Cache line refill engine with write-through store path to a fixed-latency backing memory.
// Define LINE_FILL_CRITICAL_FIRST_EN to start each refill at the requested word and wrap through the line.
module line_fill_unit #(
  parameter int WORDS_PER_LINE = 8,
  parameter int MEM_LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        hit,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] memory_word,
  output logic [2:0]  counter,
  output logic        word_valid,
  output logic        fill_done,
  output logic        busy
);

  localparam int        IW  = $clog2(WORDS_PER_LINE);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_SEND, WR_WAIT, DONE} state_t;

  state_t          state, next_state;
  logic [31:IW+2]  base_hi;
  logic [IW-1:0]   idx, idx_nxt, start_idx;
  logic [IW:0]     sent;
  logic [3:0]      lat;
  logic            rd_miss, last_word;
  logic            unused_addr_lsb;

`ifdef LINE_FILL_CRITICAL_FIRST_EN
  assign start_idx = addr[IW+1:2];
`else
  assign start_idx = '0;
`endif

  assign unused_addr_lsb = ^addr[1:0];
  assign rd_miss   = MemRead && !hit && !MemWrite;
  assign last_word = (sent == (IW+1)'(WORDS_PER_LINE - 1));
  assign idx_nxt   = idx + IW'(1);
  assign busy      = (state != IDLE) || MemWrite || rd_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (MemWrite)     next_state = WR_WAIT;
                else if (rd_miss) next_state = RD_ISSUE;
      RD_ISSUE: next_state = (MEM_LATENCY == 1) ? RD_SEND : RD_WAIT;
      RD_WAIT:  if (lat <= 4'd1) next_state = RD_SEND;
      RD_SEND:  next_state = last_word ? DONE : RD_ISSUE;
      WR_WAIT:  if (lat <= 4'd1) next_state = IDLE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Strobes are registered on the transition so they are high for exactly the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      memory_word <= '0;
      counter     <= '0;
      word_valid  <= 1'b0;
      fill_done   <= 1'b0;
      base_hi     <= '0;
      idx         <= '0;
      sent        <= '0;
      lat         <= '0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      word_valid <= 1'b0;
      fill_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (MemWrite) begin
            mem_we    <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
            lat       <= LAT;
          end else if (rd_miss) begin
            base_hi  <= addr[31:IW+2];
            idx      <= start_idx;
            sent     <= '0;
            mem_re   <= 1'b1;
            mem_addr <= {addr[31:IW+2], start_idx, 2'b00};
          end
        end
        RD_ISSUE: lat <= LAT - 4'd1;
        RD_WAIT:  lat <= lat - 4'd1;
        RD_SEND: begin
          memory_word <= mem_rdata;
          counter     <= 3'(idx);
          word_valid  <= 1'b1;
          sent        <= sent + (IW+1)'(1);
          if (last_word) begin
            fill_done <= 1'b1;
          end else begin
            idx      <= idx_nxt;
            mem_re   <= 1'b1;
            mem_addr <= {base_hi, idx_nxt, 2'b00};
          end
        end
        WR_WAIT: lat <= lat - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: two geometries (8 words/lat 2, 4 words/lat 1) driven in lockstep,
// each against a delay-line memory and a per-cycle schedule derived from the fill/store rules.
module tb_line_fill_unit;
  localparam int W0 = 8, L0 = 2, W1 = 4, L1 = 1;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic        MemRead, MemWrite, hit;
  logic [31:0] addr, wdata;
  logic [31:0] ma0, ma1, wd0, wd1, rd0, rd1, mw0, mw1;
  logic        re0, re1, we0, we1, wv0, wv1, fd0, fd1, bz0, bz1;
  logic [2:0]  cnt0, cnt1;
  logic [31:0] seed;

  int checks, errors;
  logic [31:0] exp_mw [2];
  logic [2:0]  exp_cnt[2];

  line_fill_unit #(.WORDS_PER_LINE(W0), .MEM_LATENCY(L0)) u0 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .hit(hit), .addr(addr), .wdata(wdata),
    .mem_addr(ma0), .mem_re(re0), .mem_we(we0), .mem_wdata(wd0), .mem_rdata(rd0),
    .memory_word(mw0), .counter(cnt0), .word_valid(wv0), .fill_done(fd0), .busy(bz0));

  line_fill_unit #(.WORDS_PER_LINE(W1), .MEM_LATENCY(L1)) u1 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .hit(hit), .addr(addr), .wdata(wdata),
    .mem_addr(ma1), .mem_re(re1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd1),
    .memory_word(mw1), .counter(cnt1), .word_valid(wv1), .fill_done(fd1), .busy(bz1));

  function automatic logic [31:0] mdata(input logic [31:0] a, input logic [31:0] sd);
    return (a * 32'h9E37_79B1) ^ sd;
  endfunction

  // Backing memory: read data for a request made in cycle t is presented in cycle t+L only.
  logic        pv0[16], pv1[16];
  logic [31:0] pa0[16], pa1[16];
  always @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 16; i++) pv0[i] <= 1'b0;
    else begin
      pv0[0] <= re0; pa0[0] <= ma0;
      for (int i = 1; i < 16; i++) begin pv0[i] <= pv0[i-1]; pa0[i] <= pa0[i-1]; end
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) for (int j = 0; j < 16; j++) pv1[j] <= 1'b0;
    else begin
      pv1[0] <= re1; pa1[0] <= ma1;
      for (int j = 1; j < 16; j++) begin pv1[j] <= pv1[j-1]; pa1[j] <= pa1[j-1]; end
    end
  end
  assign rd0 = pv0[L0-1] ? mdata(pa0[L0-1], seed) : 32'h0BAD_F00D;
  assign rd1 = pv1[L1-1] ? mdata(pa1[L1-1], seed) : 32'h0BAD_F00D;

  function automatic int wpl(input int d); return d ? W1 : W0; endfunction
  function automatic int mlat(input int d); return d ? L1 : L0; endfunction
  function automatic logic [31:0] base_of(input int d, input logic [31:0] a);
    return a & ~(32'(wpl(d) * 4) - 32'd1);
  endfunction
  function automatic int start_of(input int d, input logic [31:0] a);
`ifdef LINE_FILL_CRITICAL_FIRST_EN
    return int'((a >> 2) % 32'(wpl(d)));
`else
    return (a == 32'hFFFF_FFFF && d > 9) ? 1 : 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle c counts from the first cycle after the miss was accepted; word k is read at k*(L+1)
  // and delivered at (k+1)*(L+1); the line completes at W*(L+1).
  task automatic chk_fill(input int d, input int c, input int s, input logic [31:0] base,
                          input logic re, we, wv, fd, bz, input logic [31:0] ma, mw, input logic [2:0] cnt);
    int W = wpl(d), P = mlat(d) + 1;
    int k = c / P;
    bit on = (c % P == 0);
    bit e_re = on && k < W;
    bit e_wv = on && c > 0 && k <= W;
    string t = $sformatf("d%0d c%0d", d, c);
    if (e_wv) begin
      int wi = (s + k - 1) % W;
      exp_cnt[d] = 3'(wi);
      exp_mw[d]  = mdata(base + 32'(4 * wi), seed);
    end
    chk({t, " mem_re"}, 32'(re), 32'(e_re));
    if (e_re) chk({t, " mem_addr"}, ma, base + 32'(4 * ((s + k) % W)));
    chk({t, " mem_we"}, 32'(we), 32'd0);
    chk({t, " word_valid"}, 32'(wv), 32'(e_wv));
    chk({t, " fill_done"}, 32'(fd), 32'(c == W * P));
    chk({t, " busy"}, 32'(bz), 32'(c <= W * P));
    chk({t, " memory_word"}, mw, exp_mw[d]);
    chk({t, " counter"}, 32'(cnt), 32'(exp_cnt[d]));
  endtask

  task automatic chk_store(input int d, input int c, input logic [31:0] a, input logic [31:0] wdv,
                           input logic re, we, wv, fd, bz, input logic [31:0] ma, wd, mw, input logic [2:0] cnt);
    string t = $sformatf("d%0d st c%0d", d, c);
    chk({t, " mem_we"}, 32'(we), 32'(c == 0));
    if (c == 0) begin
      chk({t, " mem_addr"}, ma, a & 32'hFFFF_FFFC);
      chk({t, " mem_wdata"}, wd, wdv);
    end
    chk({t, " mem_re"}, 32'(re), 32'd0);
    chk({t, " word_valid"}, 32'(wv), 32'd0);
    chk({t, " fill_done"}, 32'(fd), 32'd0);
    chk({t, " busy"}, 32'(bz), 32'(c < mlat(d)));
    chk({t, " memory_word"}, mw, exp_mw[d]);
    chk({t, " counter"}, 32'(cnt), 32'(exp_cnt[d]));
  endtask

  task automatic chk_zero(input int d, input logic re, we, wv, fd, bz,
                          input logic [31:0] ma, wd, mw, input logic [2:0] cnt);
    string t = $sformatf("d%0d rst", d);
    exp_mw[d] = '0; exp_cnt[d] = '0;
    chk({t, " mem_re"}, 32'(re), 32'd0);
    chk({t, " mem_we"}, 32'(we), 32'd0);
    chk({t, " word_valid"}, 32'(wv), 32'd0);
    chk({t, " fill_done"}, 32'(fd), 32'd0);
    chk({t, " busy"}, 32'(bz), 32'd0);
    chk({t, " mem_addr"}, ma, 32'd0);
    chk({t, " mem_wdata"}, wd, 32'd0);
    chk({t, " memory_word"}, mw, 32'd0);
    chk({t, " counter"}, 32'(cnt), 32'd0);
  endtask

  task automatic zero_both();
    chk_zero(0, re0, we0, wv0, fd0, bz0, ma0, wd0, mw0, cnt0);
    chk_zero(1, re1, we1, wv1, fd1, bz1, ma1, wd1, mw1, cnt1);
  endtask

  task automatic idle_both();
    chk_fill(0, 1000, 0, 0, re0, we0, wv0, fd0, bz0, ma0, mw0, cnt0);
    chk_fill(1, 1000, 0, 0, re1, we1, wv1, fd1, bz1, ma1, mw1, cnt1);
  endtask

  // Called at a negedge. abort_c >= 0 asserts reset right after checking that cycle.
  task automatic run_miss(input logic [31:0] a, input bit noise, input int abort_c);
    int s0 = start_of(0, a), s1 = start_of(1, a);
    logic [31:0] b0 = base_of(0, a), b1 = base_of(1, a);
    MemRead = 1; MemWrite = 0; hit = 0; addr = a; wdata = $urandom;
    #1;
    chk("d0 miss accept busy", 32'(bz0), 32'd1);
    chk("d1 miss accept busy", 32'(bz1), 32'd1);
    @(posedge clk); #1;
    MemRead = 0;
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      chk_fill(0, c, s0, b0, re0, we0, wv0, fd0, bz0, ma0, mw0, cnt0);
      chk_fill(1, c, s1, b1, re1, we1, wv1, fd1, bz1, ma1, mw1, cnt1);
      if (c == abort_c) begin
        rst = 1; #1;
        zero_both();
        @(negedge clk);
        zero_both();
        rst = 0;
        repeat (4) begin @(negedge clk); idle_both(); end
        return;
      end
      if (noise && c >= 1 && c <= 5) begin
        MemRead = 1'($urandom); MemWrite = 1'($urandom); hit = 1'($urandom);
        addr = $urandom; wdata = $urandom;
      end else begin
        MemRead = 0; MemWrite = 0;
      end
    end
  endtask

  task automatic run_hit(input logic [31:0] a);
    MemRead = 1; MemWrite = 0; hit = 1; addr = a;
    #1;
    chk("d0 hit busy", 32'(bz0), 32'd0);
    chk("d1 hit busy", 32'(bz1), 32'd0);
    repeat (3) begin @(negedge clk); idle_both(); end
    MemRead = 0; hit = 0;
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] wdv, input bit rd);
    MemWrite = 1; MemRead = rd; hit = 1'($urandom); addr = a; wdata = wdv;
    #1;
    chk("d0 store accept busy", 32'(bz0), 32'd1);
    chk("d1 store accept busy", 32'(bz1), 32'd1);
    @(posedge clk); #1;
    MemWrite = 0; MemRead = 0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk_store(0, c, a, wdv, re0, we0, wv0, fd0, bz0, ma0, wd0, mw0, cnt0);
      chk_store(1, c, a, wdv, re1, we1, wv1, fd1, bz1, ma1, wd1, mw1, cnt1);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    seed = $urandom;
    MemRead = 0; MemWrite = 0; hit = 0; addr = 0; wdata = 0;
    rst = 0;
    #1 rst = 1;
    #1 zero_both();
    @(negedge clk); rst = 0;
    @(negedge clk); idle_both();

    run_miss(32'h0000_0014, 1'b0, -1);
    run_hit(32'h0000_0014);
    run_store(32'h0000_0043, 32'hDEAD_BEEF, 1'b1);
    run_miss(32'h0000_0014, 1'b0, 9);
    run_miss(32'h0000_0014, 1'b0, -1);

    for (int n = 0; n < 10; n++) begin
      int kind = $urandom_range(0, 2);
      logic [31:0] ra = $urandom;
      case (kind)
        0: run_miss(ra, 1'b1, -1);
        1: run_hit(ra);
        default: run_store(ra, $urandom, 1'($urandom));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_fill_unit.md
LINE_FILL_UNIT -- requirements
Module: line_fill_unit

Interface
REQ-001 Parameter WORDS_PER_LINE, default 8, words per cache line; power of two, 2..8.
REQ-002 Parameter MEM_LATENCY, default 2, backing-memory read/write latency in cycles, 1..15.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 MemRead  input  1  MEM-stage load request from cache side.
REQ-006 MemWrite  input  1  MEM-stage store request (write-through).
REQ-007 hit  input  1  cache hit for the current addr.
REQ-008 addr  input  32  byte address of request.
REQ-009 wdata  input  32  store data.
REQ-010 mem_addr  output  32  word-aligned backing-memory address.
REQ-011 mem_re / mem_we  output  1 each  backing-memory read / write strobes, one cycle per access.
REQ-012 mem_wdata  output  32  backing-memory write data.
REQ-013 mem_rdata  input  32  backing-memory read data, valid exactly MEM_LATENCY cycles after mem_re.
REQ-014 memory_word  output  32  refill word to cache.
REQ-015 counter  output  3  word index within line of memory_word.
REQ-016 word_valid  output  1  one-cycle pulse: memory_word/counter valid, cache must latch.
REQ-017 fill_done  output  1  one-cycle pulse after the last refill word.
REQ-018 busy  output  1  stall request to hazard logic.

Function
REQ-019 FSM states IDLE, RD_ISSUE, RD_WAIT, RD_SEND, WR_WAIT, DONE.
REQ-020 IDLE: MemWrite=1 -> latch addr/wdata, pulse mem_we with mem_addr={addr[31:2],2'b00}, go WR_WAIT; MemWrite wins when MemRead is also 1.
REQ-021 IDLE: MemRead=1 & hit=0 & MemWrite=0 -> latch line base (addr with low log2(WORDS_PER_LINE)+2 bits cleared) and start index, go RD_ISSUE.
REQ-022 IDLE: MemRead=1 & hit=1 -> no action, remain IDLE.
REQ-023 RD_ISSUE: pulse mem_re, mem_addr = base + 4*index; go RD_WAIT; latency counter loaded with MEM_LATENCY-1.
REQ-024 RD_WAIT: decrement latency counter; at 0 go RD_SEND (RD_WAIT lasts MEM_LATENCY-1 cycles, skipped when MEM_LATENCY=1).
REQ-025 RD_SEND: memory_word<=mem_rdata, counter<=index, word_valid=1 for that cycle; if WORDS_PER_LINE words sent go DONE, else index<=(index+1) mod WORDS_PER_LINE, go RD_ISSUE.
REQ-026 Per word cost: MEM_LATENCY+1 cycles; full line = WORDS_PER_LINE*(MEM_LATENCY+1) cycles from RD_ISSUE entry to DONE entry.
REQ-027 DONE: fill_done=1 one cycle, go IDLE; new requests ignored during DONE.
REQ-028 WR_WAIT: hold MEM_LATENCY cycles then return to IDLE; no second mem_we.
REQ-029 busy combinational: 1 when state!=IDLE, or in IDLE when a miss read or a write is being accepted; 0 in IDLE on hit or no request.
REQ-030 Requests arriving while state!=IDLE are ignored; requester holds them under busy.
REQ-031 Index wraps modulo WORDS_PER_LINE; counter upper bits zero when WORDS_PER_LINE<8.
REQ-032 memory_word and counter hold last value between word_valid pulses.

Reset
REQ-033 rst=1 forces IDLE immediately, regardless of state, including mid-fill or mid-write.
REQ-034 Reset values: memory_word=0, counter=0, mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0, word_valid=0, fill_done=0; busy=0 unless an IDLE request is present.
REQ-035 No fill_done or word_valid is produced for a fill aborted by reset.

Configuration
REQ-036 Macro LINE_FILL_CRITICAL_FIRST_EN defined: start index = requested word addr[log2(WORDS_PER_LINE)+1:2], fill wraps through the line.
REQ-037 Macro undefined: start index always 0; words delivered in order 0..WORDS_PER_LINE-1.

Verification
REQ-038 Miss, macro off, defaults: MemRead=1,hit=0,addr=0x0000_0014 -> mem_re at 0x00,0x04..0x1C; counter 0..7 with word_valid every 3 cycles; fill_done 24 cycles after RD_ISSUE entry.
REQ-039 Same miss, macro on -> counter sequence 5,6,7,0,1,2,3,4; mem_addr 0x14,0x18,0x1C,0x00,...,0x10.
REQ-040 Hit: MemRead=1,hit=1 -> busy=0, no mem_re, state stays IDLE.
REQ-041 Store: MemWrite=1,addr=0x0000_0043,wdata=0xDEAD_BEEF -> one mem_we, mem_addr=0x40, mem_wdata=0xDEADBEEF, busy high 3 cycles total; MemRead=1 same cycle ignored.
REQ-042 rst asserted after third word_valid -> outputs zero same cycle, no further word_valid/fill_done; next miss restarts cleanly.
REQ-043 MEM_LATENCY=1, WORDS_PER_LINE=4 -> word_valid every 2 cycles, counter 0..3, fill_done after 8 cycles.
